// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, slot states and bus layouts for the fetch stage (IF_ADEF_EN widens the decode bus)
package if_stage_pkg;

    localparam int BR_BUS_WD = 34;

`ifdef IF_ADEF_EN
    localparam int FS_TO_DS_BUS_WD = 65;
`else
    localparam int FS_TO_DS_BUS_WD = 64;
`endif

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    // Occupancy of the single IF instruction slot
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_WAIT  = 2'd1,
        SLOT_VALID = 2'd2
    } slot_t;

    // Branch information coming back from decode
    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Sequential PC step; wraps modulo 2^32
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// rtl/if_stage_npc_sel.sv - combinational next-fetch-address mux
module npc_sel
    import if_stage_pkg::*;
(
    input  logic [31:0]          seq_pc,
    input  logic [BR_BUS_WD-1:0] br_bus,
    input  logic                 ds_allowin,
    input  logic                 slot_valid,
    input  logic                 br_buf_valid,
    input  logic                 br_buf_pending_ds,
    input  logic [31:0]          br_buf_target,
    input  logic                 hold_valid,
    input  logic [31:0]          hold_addr,
    output logic [31:0]          npc,
    output logic                 use_buf
);

    br_bus_t     br;
    logic        br_evt;
    logic [31:0] seq_next;

    assign br       = br_bus_t'(br_bus);
    assign br_evt   = br.taken & ~br.stall & ds_allowin;
    assign seq_next = pc_step(seq_pc);

    // Redirect in the same cycle when the delay slot is the held instruction;
    // a buffered target waits until its delay slot has itself been issued;
    // a stalled request otherwise keeps its address until accepted.
    always_comb begin
        npc     = seq_next;
        use_buf = 1'b0;
        if (br_evt && slot_valid) begin
            npc = br.target;
        end else if (br_buf_valid && !br_buf_pending_ds) begin
            npc     = br_buf_target;
            use_buf = 1'b1;
        end else if (hold_valid) begin
            npc = hold_addr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with one-entry slot and delay-slot branch handling (optional IF_ADEF_EN)
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_wdata,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    // seq_pc starts one word below RESET_PC so the first sequential step lands on it
    localparam logic [31:0] SEQ_PC_INIT = RESET_PC - 32'd4;

    slot_t       slot;
    br_bus_t     br;
    logic [31:0] seq_pc;
    logic [31:0] inst_r;
    logic [31:0] npc;
    logic [31:0] hold_addr;
    logic [31:0] br_buf_target;
    logic        hold_valid;
    logic        br_buf_valid;
    logic        br_buf_pending_ds;
    logic        use_buf;
    logic        br_evt;
    logic        issue_slot;
    logic        fire;
    logic        adef_take;
    logic        take;

    assign br     = br_bus_t'(br_bus);
    assign br_evt = br.taken & ~br.stall & ds_allowin;

    // The slot can accept a new fetch when empty, or when its instruction leaves this cycle
    assign issue_slot = ~reset & ((slot == SLOT_EMPTY) | ((slot == SLOT_VALID) & ds_allowin));

    npc_sel u_npc_sel (
        .seq_pc            (seq_pc),
        .br_bus            (br_bus),
        .ds_allowin        (ds_allowin),
        .slot_valid        (slot == SLOT_VALID),
        .br_buf_valid      (br_buf_valid),
        .br_buf_pending_ds (br_buf_pending_ds),
        .br_buf_target     (br_buf_target),
        .hold_valid        (hold_valid),
        .hold_addr         (hold_addr),
        .npc               (npc),
        .use_buf           (use_buf)
    );

`ifdef IF_ADEF_EN
    logic misaligned;
    logic adef_r;

    assign misaligned    = npc[1:0] != 2'b00;
    assign adef_take     = issue_slot & misaligned;
    assign inst_sram_req = issue_slot & ~misaligned;
    assign fs_to_ds_bus  = {adef_r, inst_r, seq_pc};

    // Address-error flag travels with the held slot entry
    always_ff @(posedge clk) begin
        if (reset) begin
            adef_r <= 1'b0;
        end else if (adef_take) begin
            adef_r <= 1'b1;
        end else if (inst_sram_data_ok) begin
            adef_r <= 1'b0;
        end
    end
`else
    assign adef_take     = 1'b0;
    assign inst_sram_req = issue_slot;
    assign fs_to_ds_bus  = {inst_r, seq_pc};
`endif

    assign fire           = inst_sram_req & inst_sram_addr_ok;
    assign take           = fire | adef_take;
    assign inst_sram_addr = npc;
    assign fs_to_ds_valid = slot == SLOT_VALID;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;

    // Slot state machine, held instruction word and last-issued address
    always_ff @(posedge clk) begin
        if (reset) begin
            slot   <= SLOT_EMPTY;
            seq_pc <= SEQ_PC_INIT;
            inst_r <= 32'd0;
        end else begin
            unique case (slot)
                SLOT_EMPTY: begin
                    if (fire) begin
                        slot <= SLOT_WAIT;
                    end else if (adef_take) begin
                        slot <= SLOT_VALID;
                    end
                end
                SLOT_WAIT: begin
                    if (inst_sram_data_ok) begin
                        slot   <= SLOT_VALID;
                        inst_r <= inst_sram_rdata;
                    end
                end
                SLOT_VALID: begin
                    if (fire) begin
                        slot <= SLOT_WAIT;
                    end else if (ds_allowin && !adef_take) begin
                        slot <= SLOT_EMPTY;
                    end
                end
                default: slot <= SLOT_EMPTY;
            endcase
            if (adef_take) begin
                inst_r <= 32'd0;
            end
            if (take) begin
                seq_pc <= npc;
            end
        end
    end

    // Freeze the address of a request the SRAM has not yet accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_addr  <= 32'd0;
        end else if (inst_sram_req && !inst_sram_addr_ok) begin
            hold_valid <= 1'b1;
            hold_addr  <= npc;
        end else if (fire) begin
            hold_valid <= 1'b0;
        end
    end

    // Remember a branch whose delay slot is still in flight (or not yet issued)
    always_ff @(posedge clk) begin
        if (reset) begin
            br_buf_valid      <= 1'b0;
            br_buf_target     <= 32'd0;
            br_buf_pending_ds <= 1'b0;
        end else begin
            if (take && use_buf) begin
                br_buf_valid <= 1'b0;
            end else if (br_evt && slot != SLOT_VALID && !br_buf_valid) begin
                br_buf_valid      <= 1'b1;
                br_buf_target     <= br.target;
                br_buf_pending_ds <= (slot == SLOT_EMPTY) && !take;
            end
            if (take && br_buf_pending_ds) begin
                br_buf_pending_ds <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a variable-latency instruction SRAM model
module tb_if_stage;
    import if_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_req;
    logic                       inst_sram_wr;
    logic [1:0]                 inst_sram_size;
    logic [3:0]                 inst_sram_wstrb;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_addr;
    logic                       inst_sram_addr_ok;
    logic                       inst_sram_data_ok;
    logic [31:0]                inst_sram_rdata;

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    assign br_bus = {br_stall, br_taken, br_target};

    always #5 clk = ~clk;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr_q[$];
    logic [64:0] exp_dlv_q[$];

    bit          addr_ok_en;
    int          dly;
    bit          pend;
    logic [31:0] pend_addr;
    int          cnt;

    logic        stalled_prev;
    logic [31:0] addr_prev;
    logic        dok_prev;
    logic        br_evt_tb;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h24010001;
        return a ^ 32'h0f0f0f0f;
    endfunction

    function automatic logic [64:0] dlv(input logic [31:0] pc);
        return {1'b0, mem(pc), pc};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fs_to_ds_valid && fs_to_ds_bus[31:0] == pc) && n < 200);
        if (!(fs_to_ds_valid && fs_to_ds_bus[31:0] == pc)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pc: timeout waiting for pc %h", pc);
        end
    endtask

    // SRAM model: accepts when enabled, returns data dly cycles after addr_ok
    initial begin
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        pend = 1'b0; pend_addr = 32'd0; cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            inst_sram_data_ok = 1'b0;
            if (reset) begin
                pend = 1'b0;
                inst_sram_addr_ok = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        inst_sram_data_ok = 1'b1;
                        inst_sram_rdata   = mem(pend_addr);
                        pend = 1'b0;
                    end
                end
                inst_sram_addr_ok = addr_ok_en & inst_sram_req;
                if (inst_sram_addr_ok) begin
                    pend = 1'b1;
                    pend_addr = inst_sram_addr;
                    cnt = dly;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on accepted requests and delivered instructions
    initial begin
        stalled_prev = 1'b0; addr_prev = 32'd0; dok_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                br_evt_tb = br_taken & ~br_stall & ds_allowin;
                if (stalled_prev && !br_evt_tb) begin
                    check("req_hold", 65'(inst_sram_req), 65'(1'b1));
                    check("addr_hold", 65'(inst_sram_addr), 65'(addr_prev));
                end
                if (dok_prev) check("valid_after_data_ok", 65'(fs_to_ds_valid), 65'(1'b1));
                if (inst_sram_data_ok) check("data_ok_in_wait", 65'(fs_to_ds_valid), 65'(1'b0));
                if ((pend || inst_sram_data_ok) && !inst_sram_addr_ok)
                    check("no_req_while_outstanding", 65'(inst_sram_req), 65'(1'b0));
                if (inst_sram_req && inst_sram_addr_ok) begin
                    if (exp_addr_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL req_addr: got %h, none expected", inst_sram_addr);
                    end else begin
                        check("req_addr", 65'(inst_sram_addr), 65'(exp_addr_q.pop_front()));
                    end
                end
                if (fs_to_ds_valid && ds_allowin) begin
                    if (exp_dlv_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL deliver: got %h, none expected", fs_to_ds_bus);
                    end else begin
                        check("deliver", 65'(fs_to_ds_bus), exp_dlv_q.pop_front());
                    end
                end
            end
            stalled_prev = ~reset & inst_sram_req & ~inst_sram_addr_ok;
            addr_prev    = inst_sram_addr;
            dok_prev     = inst_sram_data_ok;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1; ds_allowin = 1'b0;
        br_stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        addr_ok_en = 1'b1; dly = 1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_valid", 65'(fs_to_ds_valid), 65'(1'b0));
        check("reset_req", 65'(inst_sram_req), 65'(1'b0));
        check("tied_outputs", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
              65'({1'b0, 2'd2, 4'd0, 32'd0}));

        // Reset fetch
        @(negedge clk);
        exp_addr_q.push_back(32'hbfc00000);
        reset = 1'b0;
        #2 check("first_req", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hbfc00000}));
        @(negedge clk);
        #2 check("valid_not_early", 65'(fs_to_ds_valid), 65'(1'b0));
        @(negedge clk);
        #2 check("first_valid", 65'({fs_to_ds_valid, 65'(fs_to_ds_bus)}), {1'b1, 1'b0, 32'h24010001, 32'hbfc00000});

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 65'(fs_to_ds_valid), 65'(1'b1));
            check("bp_bus", 65'(fs_to_ds_bus), {1'b0, 32'h24010001, 32'hbfc00000});
            check("bp_req", 65'(inst_sram_req), 65'(1'b0));
            @(negedge clk);
            #2;
        end
        exp_addr_q.push_back(32'hbfc00004);
        exp_dlv_q.push_back({1'b0, 32'h24010001, 32'hbfc00000});
        ds_allowin = 1'b1;
        #1 check("bp_release", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hbfc00004}));

        // Branch with delay slot VALID
        exp_addr_q.push_back(32'hbfc00008);
        exp_addr_q.push_back(32'hbfc0000c);
        exp_addr_q.push_back(32'hbfc00010);
        exp_addr_q.push_back(32'hbfc00100);
        exp_dlv_q.push_back(dlv(32'hbfc00004));
        exp_dlv_q.push_back(dlv(32'hbfc00008));
        exp_dlv_q.push_back(dlv(32'hbfc0000c));
        exp_dlv_q.push_back(dlv(32'hbfc00010));
        wait_pc(32'hbfc00010);
        br_taken = 1'b1; br_target = 32'hbfc00100;
        #2 check("br_valid_target", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hbfc00100}));
        @(negedge clk);
        br_taken = 1'b0;

        // Branch with delay slot WAIT, data returns three cycles after the branch leaves
        exp_addr_q.push_back(32'hbfc00104);
        exp_addr_q.push_back(32'hbfc00108);
        exp_addr_q.push_back(32'hbfc0010c);
        exp_addr_q.push_back(32'hbfc00110);
        exp_addr_q.push_back(32'hbfc00200);
        exp_dlv_q.push_back(dlv(32'hbfc00100));
        exp_dlv_q.push_back(dlv(32'hbfc00104));
        exp_dlv_q.push_back(dlv(32'hbfc00108));
        exp_dlv_q.push_back(dlv(32'hbfc0010c));
        exp_dlv_q.push_back(dlv(32'hbfc00110));
        wait_pc(32'hbfc0010c);
        dly = 4;
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'hbfc00200;
        @(negedge clk);
        br_taken = 1'b0; dly = 1;
        #2 check("br_buf_set", 65'({dut.br_buf_valid, inst_sram_req}), 65'({1'b1, 1'b0}));
        wait_pc(32'hbfc00110);
        #2 check("br_buf_target", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hbfc00200}));
        @(negedge clk);
        #2 check("br_buf_clear", 65'(dut.br_buf_valid), 65'(1'b0));

        // br_stall holds the redirect until released
        exp_addr_q.push_back(32'hbfc00204);
        exp_addr_q.push_back(32'hbfc00208);
        exp_addr_q.push_back(32'hbfc00300);
        exp_dlv_q.push_back(dlv(32'hbfc00200));
        exp_dlv_q.push_back(dlv(32'hbfc00204));
        exp_dlv_q.push_back(dlv(32'hbfc00208));
        wait_pc(32'hbfc00208);
        ds_allowin = 1'b0; br_taken = 1'b1; br_stall = 1'b1; br_target = 32'hbfc00300;
        #2 check("stall_no_req_0", 65'(inst_sram_req), 65'(1'b0));
        @(negedge clk);
        #2 check("stall_no_req_1", 65'({inst_sram_req, fs_to_ds_valid, fs_to_ds_bus[31:0]}),
                 65'({1'b0, 1'b1, 32'hbfc00208}));
        @(negedge clk);
        br_stall = 1'b0; ds_allowin = 1'b1;
        #2 check("stall_release", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hbfc00300}));
        @(negedge clk);
        br_taken = 1'b0;

`ifdef IF_ADEF_EN
        // Misaligned branch target raises adef without touching the SRAM
        exp_addr_q.push_back(32'hbfc00304);
        exp_dlv_q.push_back(dlv(32'hbfc00300));
        exp_dlv_q.push_back(dlv(32'hbfc00304));
        exp_dlv_q.push_back({1'b1, 32'd0, 32'hbfc00102});
        wait_pc(32'hbfc00304);
        br_taken = 1'b1; br_target = 32'hbfc00102;
        #2 check("adef_no_req", 65'(inst_sram_req), 65'(1'b0));
        @(negedge clk);
        br_taken = 1'b0;
        #2 check("adef_bus", 65'({fs_to_ds_valid, 65'(fs_to_ds_bus)}), {1'b1, 1'b1, 32'd0, 32'hbfc00102});
        @(negedge clk);
        ds_allowin = 1'b0;
`else
        // Branch request stalled by the SRAM keeps its target; then the PC wraps
        exp_addr_q.push_back(32'hbfc00304);
        exp_addr_q.push_back(32'hfffffff8);
        exp_addr_q.push_back(32'hfffffffc);
        exp_addr_q.push_back(32'h00000000);
        exp_dlv_q.push_back(dlv(32'hbfc00300));
        exp_dlv_q.push_back(dlv(32'hbfc00304));
        exp_dlv_q.push_back(dlv(32'hfffffff8));
        exp_dlv_q.push_back(dlv(32'hfffffffc));
        wait_pc(32'hbfc00304);
        br_taken = 1'b1; br_target = 32'hfffffff8; addr_ok_en = 1'b0;
        #2 check("br_stalled_req", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hfffffff8}));
        @(negedge clk);
        br_taken = 1'b0;
        #2 check("br_held_req", 65'({inst_sram_req, inst_sram_addr}), 65'({1'b1, 32'hfffffff8}));
        @(negedge clk);
        addr_ok_en = 1'b1;
        wait_pc(32'h00000000);
        ds_allowin = 1'b0;
`endif

        repeat (6) @(negedge clk);
        #2;
        check("addr_q_drained", 65'(exp_addr_q.size()), 65'(0));
        check("dlv_q_drained", 65'(exp_dlv_q.size()), 65'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
